// File: rtl/probe_pkg.sv
// Shared constants and types for the probe capture stage: channel geometry,
// 27 MHz default timing, and the button debouncer state encoding.
package probe_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 8;

    localparam int DEF_SAMPLE_DIV      = 2_700_000;
    localparam int DEF_DEBOUNCE_CYCLES = 270_000;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_WAIT_PRESS,
        DB_PRESSED,
        DB_WAIT_RELEASE
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for an active-low bouncy push button: two-flop synchronizer and a
// four-state FSM that accepts a level only after DEBOUNCE_CYCLES stable cycles.
module btn_debounce
    import probe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic press,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    db_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Synchronizer resets to the idle (released, high) level of the button.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DB_RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        press        = 1'b0;
        case (r_state)
            DB_RELEASED: begin
                if (!r_sync2) begin
                    w_state_next = DB_WAIT_PRESS;
                    w_cnt_next   = '0;
                end
            end
            DB_WAIT_PRESS: begin
                if (r_sync2) begin
                    w_state_next = DB_RELEASED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = DB_PRESSED;
                    press        = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DB_PRESSED: begin
                if (r_sync2) begin
                    w_state_next = DB_WAIT_RELEASE;
                    w_cnt_next   = '0;
                end
            end
            DB_WAIT_RELEASE: begin
                if (!r_sync2) begin
                    w_state_next = DB_PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = DB_RELEASED;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = DB_RELEASED;
        endcase
    end

    assign level = (r_state == DB_PRESSED) || (r_state == DB_WAIT_RELEASE);

endmodule

// File: rtl/probe_sampler.sv
// Samples eight probe channels once per window (snapshot or sticky-OR) and
// presents stable bytes to the LCD monitor; a debounced button freezes them.
module probe_sampler
    import probe_pkg::*;
#(
    parameter int SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [CH_W-1:0] in_0,
    input  logic [CH_W-1:0] in_1,
    input  logic [CH_W-1:0] in_2,
    input  logic [CH_W-1:0] in_3,
    input  logic [CH_W-1:0] in_4,
    input  logic [CH_W-1:0] in_5,
    input  logic [CH_W-1:0] in_6,
    input  logic [CH_W-1:0] in_7,
    input  logic            mode,
    input  logic            freeze_btn,
    output logic [CH_W-1:0] out_0,
    output logic [CH_W-1:0] out_1,
    output logic [CH_W-1:0] out_2,
    output logic [CH_W-1:0] out_3,
    output logic [CH_W-1:0] out_4,
    output logic [CH_W-1:0] out_5,
    output logic [CH_W-1:0] out_6,
    output logic [CH_W-1:0] out_7,
    output logic            frozen,
    output logic            sample_tick
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    ch_t              w_in       [NUM_CH];
    ch_t              r_in_reg   [NUM_CH];
    ch_t              r_acc      [NUM_CH];
    ch_t              r_out      [NUM_CH];
    ch_t              w_acc_next [NUM_CH];
    ch_t              w_out_next [NUM_CH];
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic             r_frozen;
    logic             r_sample_tick;
    logic             w_press;
    logic             w_btn_level;

    assign w_in[0] = in_0;
    assign w_in[1] = in_1;
    assign w_in[2] = in_2;
    assign w_in[3] = in_3;
    assign w_in[4] = in_4;
    assign w_in[5] = in_5;
    assign w_in[6] = in_6;
    assign w_in[7] = in_7;

    assign out_0 = r_out[0];
    assign out_1 = r_out[1];
    assign out_2 = r_out[2];
    assign out_3 = r_out[3];
    assign out_4 = r_out[4];
    assign out_5 = r_out[5];
    assign out_6 = r_out[6];
    assign out_7 = r_out[7];

    assign frozen      = r_frozen;
    assign sample_tick = r_sample_tick;
    assign w_tick      = (r_cnt == CNT_LAST);

    // The accumulator holds SAMPLE_DIV-1 samples at the tick; OR-ing in the
    // current in_reg completes the window to exactly SAMPLE_DIV samples.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_acc_next[gi] = w_tick ? '0 : (r_acc[gi] | r_in_reg[gi]);
            assign w_out_next[gi] = (w_tick && !r_frozen)
                                  ? (mode ? (r_acc[gi] | r_in_reg[gi]) : r_in_reg[gi])
                                  : r_out[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_in_reg[i] <= '0;
                r_acc[i]    <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_in_reg[i] <= w_in[i];
                r_acc[i]    <= w_acc_next[i];
                r_out[i]    <= w_out_next[i];
            end
        end
    end

    // The tick sees the pre-edge freeze state, so a press landing on the tick
    // edge still lets that one update through.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frozen      <= 1'b0;
            r_sample_tick <= 1'b0;
        end else begin
            r_sample_tick <= w_tick && !r_frozen;
            if (w_press && !w_btn_level) begin
                r_frozen <= !r_frozen;
            end
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .resetn(resetn),
        .raw   (freeze_btn),
        .press (w_press),
        .level (w_btn_level)
    );

endmodule

// File: tb/tb_probe_sampler.sv
// Bench for probe_sampler with SAMPLE_DIV=4, DEBOUNCE_CYCLES=3: table of
// accumulate/snapshot windows, freeze/bounce/reset sequences, random vs model.
module tb_probe_sampler;

    localparam int SDIV = 4;
    localparam int DBC  = 3;
    localparam int NRND = 200;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       mode = 1'b0;
    logic       freeze_btn = 1'b1;
    logic [7:0] in_v  [8];
    logic [7:0] out_w [8];
    logic       sample_tick;
    logic       frozen;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       m;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] exp_o;
    } acc_vec_t;

    acc_vec_t   tbl [8];
    logic [7:0] hist [0:NRND][0:7];
    logic       mode_h [0:NRND];
    logic [7:0] exp_out [8];
    logic [7:0] w_acc;

    always #5 clk = ~clk;

    probe_sampler #(
        .SAMPLE_DIV     (SDIV),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_0       (in_v[0]),
        .in_1       (in_v[1]),
        .in_2       (in_v[2]),
        .in_3       (in_v[3]),
        .in_4       (in_v[4]),
        .in_5       (in_v[5]),
        .in_6       (in_v[6]),
        .in_7       (in_v[7]),
        .mode       (mode),
        .freeze_btn (freeze_btn),
        .out_0      (out_w[0]),
        .out_1      (out_w[1]),
        .out_2      (out_w[2]),
        .out_3      (out_w[3]),
        .out_4      (out_w[4]),
        .out_5      (out_w[5]),
        .out_6      (out_w[6]),
        .out_7      (out_w[7]),
        .frozen     (frozen),
        .sample_tick(sample_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int c = 0; c < 8; c++) in_v[c] = v;
    endtask

    task automatic wait_tick(input int maxc);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (sample_tick !== 1'b1 && i < maxc);
        chk("tick_wait", {31'd0, sample_tick}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        tbl[1] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{1'b0, 8'h01, 8'h02, 8'h04, 8'h08, 8'h08};
        tbl[3] = '{1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80};
        tbl[4] = '{1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40};
        tbl[6] = '{1'b0, 8'h33, 8'h44, 8'h55, 8'h66, 8'h66};
        tbl[7] = '{1'b1, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};

        // Reset with in_0 = A5 held; first tick 4 edges after release.
        set_all(8'h00);
        in_v[0] = 8'hA5;
        repeat (3) step();
        for (int c = 0; c < 8; c++) chk("reset_out", out_w[c], 0);
        chk("reset_tick", {31'd0, sample_tick}, 0);
        chk("reset_frozen", {31'd0, frozen}, 0);
        resetn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("first_ticks", {31'd0, sample_tick}, {31'd0, (e % SDIV) == 0});
            if (e % SDIV == 0) chk("first_out0", out_w[0], 8'hA5);
        end
        $display("reset/first-tick sequence done, out_0=%h", out_w[0]);

        // Table: each window's four in_3 samples start at the previous tick edge.
        repeat (3) step();
        for (int v = 0; v <= 8; v++) begin
            in_v[3] = (v < 8) ? tbl[v].s0 : 8'h00;
            step();
            chk("tbl_tick", {31'd0, sample_tick}, 1);
            if (v > 0) begin
                chk("tbl_out3", out_w[3], tbl[v-1].exp_o);
                $display("acc vec %0d mode=%0d out_3=%h exp=%h", v - 1, tbl[v-1].m,
                         out_w[3], tbl[v-1].exp_o);
            end
            if (v < 8) begin
                mode = tbl[v].m;
                in_v[3] = tbl[v].s1;
                step();
                chk("tbl_notick", {31'd0, sample_tick}, 0);
                in_v[3] = tbl[v].s2;
                step();
                chk("tbl_notick", {31'd0, sample_tick}, 0);
                in_v[3] = tbl[v].s3;
                step();
                chk("tbl_notick", {31'd0, sample_tick}, 0);
            end
        end

        // Freeze: press 8 cycles; frozen rises 6 edges after the fall.
        mode = 1'b0;
        set_all(8'h3C);
        wait_tick(5);
        wait_tick(5);
        for (int c = 0; c < 8; c++) chk("pre_freeze_out", out_w[c], 8'h3C);
        freeze_btn = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e <= 6) chk("freeze_latency", {31'd0, frozen}, {31'd0, e == 6});
            if (e == 6) set_all(8'hFF);
        end
        freeze_btn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("frozen_tick", {31'd0, sample_tick}, 0);
            chk("frozen_out0", out_w[0], 8'h3C);
            chk("frozen_out5", out_w[5], 8'h3C);
        end
        $display("freeze sequence: outputs held at %h", out_w[0]);
        freeze_btn = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk("unfreeze_latency", {31'd0, frozen}, {31'd0, e < 6});
        end
        wait_tick(6);
        for (int c = 0; c < 8; c++) chk("unfrozen_out", out_w[c], 8'hFF);
        freeze_btn = 1'b1;
        repeat (10) step();
        chk("unfrozen_stays", {31'd0, frozen}, 0);

        // Bounce: low 2, high 1, low 2, high -> nothing accepted.
        freeze_btn = 1'b0; step(); step();
        freeze_btn = 1'b1; step();
        freeze_btn = 1'b0; step(); step();
        freeze_btn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("bounce_frozen", {31'd0, frozen}, 0);
        end
        $display("bounce sequence done, frozen=%0d", frozen);

        // Asynchronous reset mid-window (cnt = 2).
        set_all(8'h5A);
        wait_tick(5);
        wait_tick(5);
        chk("pre_reset_out0", out_w[0], 8'h5A);
        step();
        step();
        resetn = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) chk("async_reset_out", out_w[c], 0);
        chk("async_reset_tick", {31'd0, sample_tick}, 0);
        step();
        resetn = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("post_reset_tick", {31'd0, sample_tick}, {31'd0, e == 4});
        end
        chk("post_reset_out0", out_w[0], 8'h5A);
        $display("mid-window reset sequence done, out_0=%h", out_w[0]);

        // Press lands exactly on a tick edge: that update still goes through.
        step();
        step();
        freeze_btn = 1'b0;
        set_all(8'hC3);
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e < 6) chk("coinc_prefrozen", {31'd0, frozen}, 0);
        end
        chk("coinc_tick", {31'd0, sample_tick}, 1);
        chk("coinc_out0", out_w[0], 8'hC3);
        chk("coinc_out7", out_w[7], 8'hC3);
        chk("coinc_frozen", {31'd0, frozen}, 1);
        set_all(8'h77);
        step();
        step();
        freeze_btn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk("coinc_hold_tick", {31'd0, sample_tick}, 0);
            chk("coinc_hold_out0", out_w[0], 8'hC3);
        end
        chk("coinc_still_frozen", {31'd0, frozen}, 1);
        $display("press-on-tick sequence done, out_0=%h", out_w[0]);

        // Random stimulus against a sliding-window history model.
        resetn = 1'b0;
        step();
        chk("rnd_reset_frozen", {31'd0, frozen}, 0);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            hist[0][c] = 8'h00;
            exp_out[c] = 8'h00;
        end
        for (int k = 1; k <= NRND; k++) begin
            for (int c = 0; c < 8; c++) begin
                hist[k][c] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                         : (8'h01 << $urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) hist[k][c] = 8'h00;
                in_v[c] = hist[k][c];
            end
            mode_h[k] = 1'($urandom);
            mode = mode_h[k];
            step();
            if (k % SDIV == 0) begin
                for (int c = 0; c < 8; c++) begin
                    if (mode_h[k]) begin
                        w_acc = 8'h00;
                        for (int j = k - SDIV; j <= k - 1; j++) w_acc = w_acc | hist[j][c];
                    end else begin
                        w_acc = hist[k-1][c];
                    end
                    exp_out[c] = w_acc;
                end
                $display("rnd tick at edge %0d mode=%0d out_0=%h exp=%h", k, mode_h[k],
                         out_w[0], exp_out[0]);
            end
            chk("rnd_tick", {31'd0, sample_tick}, {31'd0, (k % SDIV) == 0});
            for (int c = 0; c < 8; c++) chk("rnd_out", out_w[c], exp_out[c]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
